// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexed driver for an N-digit 7-segment display. Packed BCD
//   digits are captured into a pending buffer and copied to the display
//   buffer only at a frame boundary, so a new score never tears mid-scan.
//   One digit is enabled at a time for REFRESH_DIV clock cycles.
//
// Optional feature (macro SEVSEG_BLANK_LEADING_ZERO_EN):
//   defined     - digit k>0 is blanked when it and every higher digit are 0;
//                 digit 0 is never blanked.
//   not defined - every digit is decoded as-is.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_load     1-cycle strobe: capture i_digits into the pending buffer
//   i_digits   packed BCD, [3:0] = digit 0 (rightmost)
//   o_seg      segments {a,b,c,d,e,f,g} = [6:0], polarity per SEG_ACTIVE_LOW
//   o_an       one-hot digit enable, polarity per AN_ACTIVE_LOW
//   o_pending  pending buffer holds data not yet displayed
//   o_frame    high for the cycle whose closing edge wraps the scan to digit 0
module seven_segment_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_pending,
    output logic                    o_frame
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BUF_W = 4 * NUM_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(REFRESH_DIV - 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

    // BCD to active-high segment pattern; codes 10..15 are blank.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [BUF_W-1:0]      pend_buf;
    logic [BUF_W-1:0]      disp_buf;

    logic                  wrap;
    logic                  frame_edge;
    logic [3:0]            cur_nib;
    logic                  blank;
    logic [6:0]            seg_ah;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_onehot;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        wrap       = (div_cnt == DIV_LAST);
        frame_edge = wrap && (idx == IDX_LAST);
        cur_nib    = disp_buf[{idx, 2'b00} +: 4];
`ifdef SEVSEG_BLANK_LEADING_ZERO_EN
        // Digit and everything above it are zero; digit 0 always shows.
        blank      = (idx != '0) && ((disp_buf >> {idx, 2'b00}) == '0);
`else
        blank      = 1'b0;
`endif
        seg_ah     = blank ? 7'b0000000 : decode(cur_nib);
        seg_next   = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
        an_onehot  = NUM_DIGITS'(1) << idx;
        an_next    = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt   <= '0;
            idx       <= '0;
            pend_buf  <= '0;
            disp_buf  <= '0;
            o_pending <= 1'b0;
            o_frame   <= 1'b0;
            o_seg     <= SEG_OFF;
            o_an      <= AN_OFF;
        end else begin
            // Scan timing
            div_cnt <= wrap ? '0 : div_cnt + DIV_ONE;
            if (wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
            end
            // Announce the boundary one cycle early so o_frame coincides with
            // the cycle whose closing edge performs the buffer swap.
            o_frame <= (div_cnt == DIV_PRE) && (idx == IDX_LAST);

            // Double buffer: the swap uses pending contents from before this
            // edge; a load on the same edge refills pending and keeps it flagged.
            if (frame_edge && o_pending) begin
                disp_buf  <= pend_buf;
                o_pending <= 1'b0;
            end
            if (i_load) begin
                pend_buf  <= i_digits;
                o_pending <= 1'b1;
            end

            // Output register stage
            o_seg <= seg_next;
            o_an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FP = ND * RD;   // cycles per frame

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   digits = '0;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          pending;
    logic          frame;

    seven_segment_scanner #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_digits(digits),
        .o_seg(seg), .o_an(an), .o_pending(pending), .o_frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [15:0] v;
    } load_t;

    typedef struct {
        logic [6:0]    seg;
        logic [ND-1:0] an;
        logic          pend;
        logic          frame;
        int            c;
    } exp_t;

    load_t loads[$];
    exp_t  exp_q[$];
    int    edge_n = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [6:0] seg_tbl [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value shown during frame f: last load sampled strictly before the edge
    // that starts frame f (frame 0 shows zeros).
    function automatic logic [15:0] disp_of(input int f);
        logic [15:0] r;
        r = '0;
        foreach (loads[i]) if (loads[i].e < f * FP) r = loads[i].v;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] val, input int d);
        logic [3:0] nib;
        logic [6:0] s;
        nib = val[4*d +: 4];
        s = (nib < 10) ? seg_tbl[nib] : 7'b0000000;
`ifdef SEVSEG_BLANK_LEADING_ZERO_EN
        if (d > 0 && (val >> (4 * d)) == 16'h0) s = 7'b0000000;
`endif
        return ~s;
    endfunction

    // Reference model: runs on each edge the DUT sees, pushes what the DUT
    // should present after that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_n = 0;
            loads.delete();
            exp_q.delete();
        end else begin
            exp_t x;
            int f, d, b;
            edge_n++;
            if (load) loads.push_back('{edge_n, digits});
            f = (edge_n - 1) / FP;
            d = ((edge_n - 1) / RD) % ND;
            b = (edge_n / FP) * FP;
            x.seg   = exp_seg(disp_of(f), d);
            x.an    = ~(ND'(1) << d);
            x.pend  = (loads.size() > 0) && (loads[$].e >= b);
            x.frame = ((edge_n + 1) % FP) == 0;
            x.c     = edge_n;
            exp_q.push_back(x);
        end
    end

    // Monitor: compare on the falling edge.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("seg", 32'(seg), 32'(x.seg));
            chk("an", 32'(an), 32'(x.an));
            chk("pending", 32'(pending), 32'(x.pend));
            chk("frame", 32'(frame), 32'(x.frame));
        end
    end

    task automatic step(input logic l, input logic [15:0] v);
        @(posedge clk);
        #2;
        load   = l;
        digits = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_frame", 32'(frame), 32'h0);
    endtask

    initial begin
        int  k;
        logic seen;
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        idle(20);
        // Mid-frame load
        step(1'b1, 16'h1234); idle(2 * FP);
        // Two loads in one frame: last wins
        step(1'b1, 16'h1111); idle(3); step(1'b1, 16'h2222); idle(2 * FP);
        // Load on the boundary cycle with data pending
        step(1'b1, 16'h9999);
        seen = 1'b0;
        for (int i = 0; i < 3 * FP && !seen; i++) begin
            step(1'b0, 16'h0);
            if (frame) seen = 1'b1;
        end
        chk("frame_found", 32'(seen), 32'h1);
        load = 1'b1; digits = 16'h5555;
        idle(3 * FP);
        // Blank code and leading-zero patterns
        step(1'b1, 16'h3C21); idle(2 * FP);
        step(1'b1, 16'h0070); idle(2 * FP);
        step(1'b1, 16'h0000); idle(2 * FP);

        // Randomized loads
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            step(k == 0, 16'($urandom));
        end

        // Reset mid-scan with data pending
        step(1'b1, 16'h4321); idle(3);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        idle(2);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        idle(2 * FP);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 6);
            step(k == 0, 16'($urandom));
        end
        idle(FP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
